accel_sequencer: RTL and testbench

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

---
 rtl/accel_pkg.sv | 54 +++++
 rtl/poll_timer.sv | 31 +++
 rtl/accel_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_accel_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants and types for the accelerometer sequencer.
// The WHOAMI state only exists when ACCEL_WHOAMI_CHECK_EN is defined.
package accel_pkg;

  // Frame field widths: {rw, 1'b0, addr, wdata} in the low 16 bits of a 32-bit bus word.
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;
  localparam int BUS_W   = 32;

  // Register map of the sensor.
  localparam logic [ADDR_W-1:0] ADDR_WHOAMI  = 6'h0F;
  localparam logic [ADDR_W-1:0] ADDR_CTRL1   = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_CTRL4   = 6'h23;
  localparam logic [ADDR_W-1:0] ADDR_OUT_X_H = 6'h29;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Y_H = 6'h2B;
  localparam logic [ADDR_W-1:0] ADDR_OUT_Z_H = 6'h2D;

  localparam logic [DATA_W-1:0] WHOAMI_VAL = 8'h33;

  // Settling time after reset and bus-stall limit, in clk_in cycles.
  localparam int RESET_WAIT_CYCLES = 16;
  localparam int BUSY_TIMEOUT      = 4096;

  typedef enum logic [3:0] {
    S_RESET_WAIT = 4'd0,
`ifdef ACCEL_WHOAMI_CHECK_EN
    S_WHOAMI     = 4'd1,
`endif
    S_CFG1       = 4'd2,
    S_CFG4       = 4'd3,
    S_WAIT_TICK  = 4'd4,
    S_RD_X       = 4'd5,
    S_RD_Y       = 4'd6,
    S_RD_Z       = 4'd7,
    S_PUBLISH    = 4'd8,
    S_ERROR      = 4'd9
  } accel_state_t;

  // Sub-phase of a single SPI transfer.
  typedef enum logic [1:0] {
    PH_REQ     = 2'd0,
    PH_WAIT_LO = 2'd1,
    PH_WAIT_HI = 2'd2
  } xfer_phase_t;

  // Build the 32-bit word handed to spi_master.
  function automatic logic [BUS_W-1:0] make_frame(input logic rw,
                                                  input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] wdata);
    return {{(BUS_W-FRAME_W){1'b0}}, rw, 1'b0, addr, wdata};
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running sample-rate divider: counts 0..POLL_DIV-1 while enabled and
// emits a one-cycle tick each time it wraps.
module poll_timer #(
  parameter logic [31:0] POLL_DIV = 32'd120000
) (
  input  logic clk_in,
  input  logic nrst,
  input  logic en,
  output logic tick
);

  logic [31:0] cnt;

  // Divider counter; held at zero until enabled.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == POLL_DIV - 32'd1) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 32'd1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_sequencer.sv
// Accelerometer sequencer: configures the sensor over spi_master, then reads
// OUT_X_H/OUT_Y_H/OUT_Z_H on every poll tick and publishes the triple atomically.
// Define ACCEL_WHOAMI_CHECK_EN to add a WHOAMI identity check before configuration.
//
// spi_master handshake: a transfer is started by a one-cycle spi_request while
// spi_ready=1; spi_master drops spi_ready while busy and raises it again when
// done, and the transfer completes on the cycle spi_ready is seen high again.
// spi_data_in is a pure function of the FSM state, so it is stable for the
// whole transfer.
module accel_sequencer
  import accel_pkg::*;
#(
  parameter logic [31:0] POLL_DIV  = 32'd120000,
  parameter logic [7:0]  CTRL1_VAL = 8'h57,
  parameter logic [7:0]  CTRL4_VAL = 8'h88
) (
  input  logic               clk_in,
  input  logic               nrst,
  output logic [BUS_W-1:0]   spi_data_in,
  output logic [5:0]         spi_n_bits,
  output logic               spi_request,
  input  logic               spi_ready,
  input  logic [BUS_W-1:0]   spi_data_out,
  output logic [DATA_W-1:0]  accel_x,
  output logic [DATA_W-1:0]  accel_y,
  output logic [DATA_W-1:0]  accel_z,
  output logic               sample_valid,
  output logic               cfg_done,
  output logic               err,
  output accel_state_t       dbg_state,
  output xfer_phase_t        dbg_phase
);

  accel_state_t state, state_nxt;
  xfer_phase_t  phase, phase_nxt;

  logic [4:0]        wait_cnt;
  logic [11:0]       busy_cnt;
  logic [DATA_W-1:0] shadow_x, shadow_y, shadow_z;
  logic              tick;
  logic              is_xfer;
  logic              xfer_done;
  logic              busy_expired;
  logic [DATA_W-1:0] rdata;
  logic              unused_rdata_hi;

  assign rdata           = spi_data_out[DATA_W-1:0];
  assign unused_rdata_hi = ^spi_data_out[BUS_W-1:DATA_W];
  assign spi_n_bits      = 6'd16;
  assign dbg_state       = state;
  assign dbg_phase       = phase;

  poll_timer #(.POLL_DIV(POLL_DIV)) u_poll_timer (
    .clk_in (clk_in),
    .nrst   (nrst),
    .en     (cfg_done),
    .tick   (tick)
  );

  // Transfer status shared by next-state logic and the datapath.
  always_comb begin
    is_xfer = 1'b0;
    case (state)
`ifdef ACCEL_WHOAMI_CHECK_EN
      S_WHOAMI,
`endif
      S_CFG1, S_CFG4, S_RD_X, S_RD_Y, S_RD_Z: is_xfer = 1'b1;
      default:                                is_xfer = 1'b0;
    endcase
    spi_request  = is_xfer && (phase == PH_REQ) && spi_ready;
    xfer_done    = is_xfer && (phase == PH_WAIT_HI) && spi_ready;
    busy_expired = is_xfer && (phase != PH_REQ) && !xfer_done &&
                   (busy_cnt == 12'(BUSY_TIMEOUT - 1));
  end

  // Frame selection: each transfer state owns exactly one frame.
  always_comb begin
    spi_data_in = '0;
    case (state)
`ifdef ACCEL_WHOAMI_CHECK_EN
      S_WHOAMI: spi_data_in = make_frame(1'b1, ADDR_WHOAMI, 8'h00);
`endif
      S_CFG1:   spi_data_in = make_frame(1'b0, ADDR_CTRL1, CTRL1_VAL);
      S_CFG4:   spi_data_in = make_frame(1'b0, ADDR_CTRL4, CTRL4_VAL);
      S_RD_X:   spi_data_in = make_frame(1'b1, ADDR_OUT_X_H, 8'h00);
      S_RD_Y:   spi_data_in = make_frame(1'b1, ADDR_OUT_Y_H, 8'h00);
      S_RD_Z:   spi_data_in = make_frame(1'b1, ADDR_OUT_Z_H, 8'h00);
      default:  spi_data_in = '0;
    endcase
  end

  // Next-state logic for the sequence and the per-transfer phase.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      S_RESET_WAIT: begin
        if (wait_cnt == 5'(RESET_WAIT_CYCLES - 1)) begin
`ifdef ACCEL_WHOAMI_CHECK_EN
          state_nxt = S_WHOAMI;
`else
          state_nxt = S_CFG1;
`endif
        end
      end
      S_WAIT_TICK: if (tick) state_nxt = S_RD_X;
      S_PUBLISH:   state_nxt = S_WAIT_TICK;
      S_ERROR:     state_nxt = S_ERROR;
      default: begin
        case (phase)
          PH_REQ:     if (spi_ready)  phase_nxt = PH_WAIT_LO;
          PH_WAIT_LO: if (!spi_ready) phase_nxt = PH_WAIT_HI;
          default:    if (spi_ready)  phase_nxt = PH_REQ;
        endcase
        if (xfer_done) begin
          case (state)
`ifdef ACCEL_WHOAMI_CHECK_EN
            S_WHOAMI: state_nxt = (rdata == WHOAMI_VAL) ? S_CFG1 : S_ERROR;
`endif
            S_CFG1:   state_nxt = S_CFG4;
            S_CFG4:   state_nxt = S_WAIT_TICK;
            S_RD_X:   state_nxt = S_RD_Y;
            S_RD_Y:   state_nxt = S_RD_Z;
            default:  state_nxt = S_PUBLISH;
          endcase
        end else if (busy_expired) begin
          state_nxt = S_ERROR;
          phase_nxt = PH_REQ;
        end
      end
    endcase
  end

  // State and phase registers.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state <= S_RESET_WAIT;
      phase <= PH_REQ;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Reset settling counter and busy-timeout counter (restarted by each request).
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      wait_cnt <= '0;
      busy_cnt <= '0;
    end else begin
      if (state == S_RESET_WAIT) wait_cnt <= wait_cnt + 5'd1;
      if (spi_request)                        busy_cnt <= '0;
      else if (is_xfer && (phase != PH_REQ))  busy_cnt <= busy_cnt + 12'd1;
    end
  end

  // Shadow capture on read completion, atomic publish, sticky status flags.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      shadow_x     <= '0;
      shadow_y     <= '0;
      shadow_z     <= '0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      cfg_done     <= 1'b0;
      err          <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (xfer_done) begin
        case (state)
          S_RD_X: shadow_x <= rdata;
          S_RD_Y: shadow_y <= rdata;
          S_RD_Z: shadow_z <= rdata;
          S_CFG4: cfg_done <= 1'b1;
          default: ;
        endcase
      end
      if (state == S_PUBLISH) begin
        accel_x      <= shadow_x;
        accel_y      <= shadow_y;
        accel_z      <= shadow_z;
        sample_valid <= 1'b1;
      end
      if ((state != S_ERROR) && (state_nxt == S_ERROR)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Self-checking bench for accel_sequencer with a behavioural spi_master model.
// Expected frames and samples are queued by the stimulus; monitors pop and compare.
module tb_accel_sequencer;
  import accel_pkg::*;

  localparam logic [31:0] POLL_DIV = 32'd200;
  localparam int LAT = 40;

  logic         clk_in = 1'b0;
  logic         nrst;
  logic [31:0]  spi_data_in;
  logic [5:0]   spi_n_bits;
  logic         spi_request;
  logic         spi_ready;
  logic [31:0]  spi_data_out;
  logic [7:0]   accel_x, accel_y, accel_z;
  logic         sample_valid, cfg_done, err;
  accel_state_t dbg_state;
  xfer_phase_t  dbg_phase;

  accel_sequencer #(.POLL_DIV(POLL_DIV), .CTRL1_VAL(8'h57), .CTRL4_VAL(8'h88)) dut (
    .clk_in(clk_in), .nrst(nrst), .spi_data_in(spi_data_in), .spi_n_bits(spi_n_bits),
    .spi_request(spi_request), .spi_ready(spi_ready), .spi_data_out(spi_data_out),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .sample_valid(sample_valid),
    .cfg_done(cfg_done), .err(err), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc++;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];        // expected frames, in order
  logic [23:0] exp_s_q[$];      // expected {x,y,z} samples
  logic [7:0]  resp_q[$];       // model read data per transfer
  int          hold_q[$];       // model busy length per transfer
  int checks = 0;
  int failures = 0;
  int last_req_cyc = 0;
  int n_req = 0;
  int prev_s_cyc = -1;
  logic [31:0] req_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_xfer(input logic [15:0] frame, input logic [7:0] resp, input int hold);
    exp_q.push_back(frame);
    resp_q.push_back(resp);
    hold_q.push_back(hold);
  endtask

  task automatic expect_config();
`ifdef ACCEL_WHOAMI_CHECK_EN
    expect_xfer(16'h8F00, 8'h33, LAT);
`endif
    expect_xfer(16'h2057, 8'h00, LAT);
    expect_xfer(16'h2388, 8'h00, LAT);
  endtask

  task automatic wait_flag_cfg(input int budget);
    for (int i = 0; i < budget && !cfg_done; i++) @(negedge clk_in);
    check("cfg_done_rise", {31'd0, cfg_done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_request"}, {31'd0, spi_request}, 32'd0);
    check({tag, "_data_in"}, spi_data_in, 32'd0);
    check({tag, "_xyz"}, {8'd0, accel_x, accel_y, accel_z}, 32'd0);
    check({tag, "_flags"}, {29'd0, sample_valid, cfg_done, err}, 32'd0);
    check({tag, "_state"}, {28'd0, dbg_state}, {28'd0, S_RESET_WAIT});
  endtask

  // ---------------- spi_master model ----------------
  always begin
    logic [7:0] r;
    int h;
    @(posedge clk_in);
    if (spi_request === 1'b1) begin
      r = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
      h = (hold_q.size() != 0) ? hold_q.pop_front() : LAT;
      #1 spi_ready = 1'b0;
      repeat (h) @(posedge clk_in);
      #1;
      spi_data_out = {24'h0, r};
      spi_ready = 1'b1;
    end
  end

  // ---------------- monitor: frames, stability, samples ----------------
  always @(negedge clk_in) begin
    if (nrst === 1'b1) begin
      if (spi_request) begin
        if (exp_q.size() == 0) begin
          check("frame_unexpected", spi_data_in, 32'hFFFF_FFFF);
        end else begin
          check("frame", spi_data_in, {16'h0, exp_q.pop_front()});
        end
        check("n_bits", {26'd0, spi_n_bits}, 32'd16);
        req_frame = spi_data_in;
        last_req_cyc = cyc;
        n_req++;
      end else if (dbg_phase != PH_REQ) begin
        check("frame_stable", spi_data_in, req_frame);
      end
      if (sample_valid) begin
        if (exp_s_q.size() == 0) begin
          check("sample_unexpected", {8'd0, accel_x, accel_y, accel_z}, 32'hFFFF_FFFF);
        end else begin
          check("sample_xyz", {8'd0, accel_x, accel_y, accel_z}, {8'd0, exp_s_q.pop_front()});
        end
        if (prev_s_cyc >= 0) check("sample_interval", cyc - prev_s_cyc, POLL_DIV);
        prev_s_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [23:0] samples [5] = '{24'h12F07F, 24'h00FF80, 24'hA55A01, 24'hFE0133, 24'h7F8000};

  initial begin
    int err_cyc;
    int base;
    nrst = 1'b0;
    spi_ready = 1'b1;
    spi_data_out = '0;
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    check_reset_outputs("reset");

    // Configuration after reset release.
    expect_config();
    nrst = 1'b1;
    wait_flag_cfg(1000);
    check("cfg_frames_left", exp_q.size(), 32'd0);
    check("cfg_err", {31'd0, err}, 32'd0);

    // Five samples with distinct read data.
    for (int s = 0; s < 5; s++) begin
      expect_xfer(16'hA900, samples[s][23:16], LAT);
      expect_xfer(16'hAB00, samples[s][15:8], LAT);
      expect_xfer(16'hAD00, samples[s][7:0], LAT);
      exp_s_q.push_back(samples[s]);
    end
    for (int i = 0; i < 2000 && exp_s_q.size() != 0; i++) @(negedge clk_in);
    check("samples_left", exp_s_q.size(), 32'd0);
    check("hold_xyz", {8'd0, accel_x, accel_y, accel_z}, 32'h007F8000);

    // Busy timeout: spi_ready held low for 5000 cycles on the next X read.
    expect_xfer(16'hA900, 8'h00, 5000);
    err_cyc = -1;
    for (int i = 0; i < 6000 && err !== 1'b1; i++) @(negedge clk_in);
    if (err === 1'b1) err_cyc = cyc;
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_latency_ok",
          {31'd0, (err_cyc - last_req_cyc >= 4096) && (err_cyc - last_req_cyc <= 4097)}, 32'd1);
    check("error_state", {28'd0, dbg_state}, {28'd0, S_ERROR});
    base = n_req;
    repeat (1500) @(negedge clk_in);
    check("error_no_requests", n_req - base, 32'd0);
    check("error_err_sticky", {31'd0, err}, 32'd1);

    // Reset, reconfigure, then reset again in the middle of the Y read.
    nrst = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("reset2");
    expect_config();
    nrst = 1'b1;
    wait_flag_cfg(1000);
    expect_xfer(16'hA900, 8'h11, LAT);
    expect_xfer(16'hAB00, 8'h22, LAT);
    base = n_req;
    for (int i = 0; i < 600 && n_req < base + 2; i++) @(negedge clk_in);
    check("rdy_request_seen", n_req - base, 32'd2);
    repeat (10) @(negedge clk_in);
    nrst = 1'b0;
    @(negedge clk_in);
    check_reset_outputs("reset_mid_rdy");
    repeat (3) @(negedge clk_in);
    expect_config();
    nrst = 1'b1;
    wait_flag_cfg(1000);
    check("rerun_frames_left", exp_q.size(), 32'd0);
    check("rerun_xyz", {8'd0, accel_x, accel_y, accel_z}, 32'd0);

`ifdef ACCEL_WHOAMI_CHECK_EN
    // Wrong identity byte stops the sequence before any configuration write.
    nrst = 1'b0;
    repeat (50) @(negedge clk_in);
    resp_q.delete();
    hold_q.delete();
    expect_xfer(16'h8F00, 8'h32, LAT);
    nrst = 1'b1;
    for (int i = 0; i < 500 && err !== 1'b1; i++) @(negedge clk_in);
    check("whoami_err", {31'd0, err}, 32'd1);
    base = n_req;
    repeat (300) @(negedge clk_in);
    check("whoami_no_requests", n_req - base, 32'd0);
    check("whoami_cfg_done", {31'd0, cfg_done}, 32'd0);
`endif

    check("final_frames_left", exp_q.size(), 32'd0);
    check("final_samples_left", exp_s_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something upstream hangs.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
